// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encodings and oversampling constants.
package uart_pkg;

  localparam int OVERSAMPLE   = 16;
  localparam int START_MID    = 7;
  localparam int DBIT_DEFAULT = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// UART receive core: rx synchroniser, s_tick baud generator and the frame FSM.
// Build option UART_RX_PARITY_EN adds an even-parity bit after the data bits.
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge (and for rx high again after a break)
// START  | counting to the middle of the start bit, rejects glitches
// DATA   | sampling DBIT data bits, LSB first, at mid-bit
// PARITY | sampling the even-parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling the stop bit, reporting good frame or framing error
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEFAULT,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx,
  input  logic [9:0]      input_number,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic            parity_err
`endif
);

  localparam int NW = $clog2(DBIT + 1);

  logic            rx_meta_q, rx_sync_q;
  logic [9:0]      div_q, div_d;
  logic [9:0]      tick_cnt_q, tick_cnt_d;
  logic            s_tick;
  rx_state_e       state_q, state_d;
  logic [4:0]      s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            wait_high_q, wait_high_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic            par_bad_q, par_bad_d;
  logic            perr_q, perr_d;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // The divisor is captured only at a wrap so a mid-period change never shortens a tick.
  always_comb begin
    div_d      = div_q;
    tick_cnt_d = tick_cnt_q;
    s_tick     = 1'b0;
    if (div_q == 10'd0) begin
      div_d      = input_number;
      tick_cnt_d = 10'd0;
    end else if (tick_cnt_q == div_q - 10'd1) begin
      s_tick     = 1'b1;
      tick_cnt_d = 10'd0;
      div_d      = input_number;
    end else begin
      tick_cnt_d = tick_cnt_q + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q      <= 10'd0;
      tick_cnt_q <= 10'd0;
    end else begin
      div_q      <= div_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    n_d         = n_q;
    b_d         = b_q;
    wait_high_d = wait_high_q;
    done_d      = 1'b0;
    ferr_d      = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d   = par_bad_q;
    perr_d      = 1'b0;
`endif
    if (rx_sync_q) begin
      wait_high_d = 1'b0;
    end
    case (state_q)
      ST_IDLE: begin
        if (!rx_sync_q && !wait_high_q) begin
          state_d = ST_START;
          s_d     = 5'd0;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (s_q == 5'(START_MID)) begin
            if (!rx_sync_q) begin
              state_d = ST_DATA;
              s_d     = 5'd0;
              n_d     = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (s_q == 5'(OVERSAMPLE - 1)) begin
            s_d = 5'd0;
            b_d = {rx_sync_q, b_q[DBIT-1:1]};
            if (n_q == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (s_tick) begin
          if (s_q == 5'(OVERSAMPLE - 1)) begin
            s_d       = 5'd0;
            par_bad_d = rx_sync_q ^ (^b_q);
            state_d   = ST_STOP;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
`endif
      ST_STOP: begin
        if (s_tick) begin
          if (s_q == 5'(SB_TICK - 1)) begin
            state_d = ST_IDLE;
            if (rx_sync_q) begin
`ifdef UART_RX_PARITY_EN
              if (par_bad_q) perr_d = 1'b1;
              else           done_d = 1'b1;
`else
              done_d = 1'b1;
`endif
            end else begin
              // A low stop bit may be a break; hold off restart until the line recovers.
              ferr_d      = 1'b1;
              wait_high_d = 1'b1;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      s_q         <= 5'd0;
      n_q         <= '0;
      b_q         <= '0;
      wait_high_q <= 1'b0;
      done_q      <= 1'b0;
      ferr_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q   <= 1'b0;
      perr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      n_q         <= n_d;
      b_q         <= b_d;
      wait_high_q <= wait_high_d;
      done_q      <= done_d;
      ferr_q      <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q   <= par_bad_d;
      perr_q      <= perr_d;
`endif
    end
  end

  assign dout         = b_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err   = perr_q;
`endif

endmodule

// File: rtl/uart_receiver_fifo.sv
// UART receiver with a first-word fall-through RX FIFO in front of the host.
// Build option UART_RX_PARITY_EN enables even parity checking and the parity_err port.
module uart_receiver_fifo
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEFAULT,
  parameter int SB_TICK = 16,
  parameter int ADDR_W  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx,
  input  logic [9:0]      input_number,
  input  logic            read_en,
  output logic [DBIT-1:0] read_data,
  output logic            empty,
  output logic            full,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic            parity_err
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DBIT-1:0]   rx_byte;
  logic              push_req;
  logic              push_ok;
  logic              pop;
  logic [DBIT-1:0]   mem_q [DEPTH];
  logic [DBIT-1:0]   mem_d [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;

  uart_rx_core #(
    .DBIT    (DBIT),
    .SB_TICK (SB_TICK)
  ) u_core (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .input_number (input_number),
    .dout         (rx_byte),
    .rx_done_tick (push_req),
    .frame_err    (frame_err)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err   (parity_err)
`endif
  );

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  always_comb begin
    pop      = read_en & ~empty_q;
    push_ok  = push_req & (~full_q | pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    full_d   = full_q;
    empty_d  = empty_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = rx_byte;
      wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end
    case ({push_ok, pop})
      2'b10: begin
        empty_d = 1'b0;
        full_d  = (wr_ptr_d == rd_ptr_q);
      end
      2'b01: begin
        full_d  = 1'b0;
        empty_d = (rd_ptr_d == wr_ptr_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign read_data    = mem_q[rd_ptr_q];
  assign empty        = empty_q;
  assign full         = full_q;
  assign rx_done_tick = push_req;
  assign overrun      = push_req & full_q & ~pop;

endmodule

// File: tb/tb_uart_receiver_fifo.sv
// Self-checking bench for uart_receiver_fifo: scoreboard of expected bytes plus pulse counters.
`timescale 1ns/1ps
module tb_uart_receiver_fifo;

  localparam int DIV     = 5;
  localparam int BIT_CLK = 16 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       read_en = 1'b0;
  logic [9:0] input_number = 10'(DIV);
  logic [7:0] read_data;
  logic       empty, full, rx_done_tick, frame_err, overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int perr_cnt = 0;
  bit full_seen = 1'b0;
  logic [7:0] exp_q[$];
  int model_cnt = 0;
  int exp_ovr = 0;

  uart_receiver_fifo dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .input_number (input_number),
    .read_en      (read_en),
    .read_data    (read_data),
    .empty        (empty),
    .full         (full),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err),
    .overrun      (overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err   (parity_err)
`endif
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (rst) begin
      if (rx_done_tick === 1'b1) done_cnt++;
      if (frame_err === 1'b1) ferr_cnt++;
      if (overrun === 1'b1) ovr_cnt++;
      if (full === 1'b1) full_seen = 1'b1;
`ifdef UART_RX_PARITY_EN
      if (parity_err === 1'b1) perr_cnt++;
`endif
    end
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    @(negedge clk);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d);
`endif
    drive_bit(stop_bit);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_good(input logic [7:0] d);
    if (model_cnt < 4) begin
      exp_q.push_back(d);
      model_cnt++;
    end else begin
      exp_ovr++;
    end
    send_frame(d, 1'b1);
  endtask

  task automatic pop_check(input string name);
    logic [7:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, nothing expected to pop", name);
    end else begin
      exp = exp_q.pop_front();
      model_cnt--;
      if (empty !== 1'b0 || read_data !== exp) begin
        errors++;
        $display("FAIL %s: empty=%b read_data=%h, required empty=0 read_data=%h",
                 name, empty, read_data, exp);
      end
    end
    read_en = 1'b1;
    @(negedge clk);
    read_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_bit("reset_empty_in_rst", empty, 1'b1);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check_bit("reset_empty", empty, 1'b1);
    check_bit("reset_full", full, 1'b0);
    checks++;
    if (read_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_read_data: got %h, required 00", read_data);
    end
    check_int("reset_pulses", done_cnt + ferr_cnt + ovr_cnt, 0);
  endtask

  task automatic test_single();
    int d0 = done_cnt;
    check_bit("single_empty_before", empty, 1'b1);
    send_good(8'h51);
    check_int("single_done", done_cnt - d0, 1);
    check_bit("single_empty_after", empty, 1'b0);
    pop_check("single_pop");
    check_bit("single_empty_popped", empty, 1'b1);
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt;
    full_seen = 1'b0;
    send_good(8'h51);
    send_good(8'h55);
    send_good(8'h51);
    check_int("b2b_done", done_cnt - d0, 3);
    check_bit("b2b_full_never", full_seen, 1'b0);
    pop_check("b2b_pop0");
    pop_check("b2b_pop1");
    pop_check("b2b_pop2");
    check_bit("b2b_empty_end", empty, 1'b1);
  endtask

  task automatic test_overrun();
    int d0 = done_cnt;
    int o0 = ovr_cnt;
    exp_ovr = 0;
    send_good(8'h11);
    send_good(8'h22);
    send_good(8'h33);
    check_bit("ovr_not_full_3", full, 1'b0);
    send_good(8'h44);
    check_bit("ovr_full_4", full, 1'b1);
    check_int("ovr_none_yet", ovr_cnt - o0, 0);
    send_good(8'h55);
    check_int("ovr_done", done_cnt - d0, 5);
    check_int("ovr_pulse", ovr_cnt - o0, exp_ovr);
    check_bit("ovr_full_kept", full, 1'b1);
    pop_check("ovr_pop0");
    check_bit("ovr_full_cleared", full, 1'b0);
    pop_check("ovr_pop1");
    pop_check("ovr_pop2");
    pop_check("ovr_pop3");
    check_bit("ovr_empty_end", empty, 1'b1);
    read_en = 1'b1;
    @(negedge clk);
    read_en = 1'b0;
    @(negedge clk);
    check_bit("ovr_read_while_empty", empty, 1'b1);
  endtask

  task automatic test_frame_err();
    int d0 = done_cnt;
    int f0 = ferr_cnt;
    send_frame(8'hA5, 1'b0);
    check_int("ferr_pulse", ferr_cnt - f0, 1);
    check_int("ferr_no_done", done_cnt - d0, 0);
    check_bit("ferr_empty", empty, 1'b1);
    send_good(8'h3C);
    check_int("ferr_next_done", done_cnt - d0, 1);
    pop_check("ferr_next_pop");
  endtask

  task automatic test_glitch();
    int s0 = done_cnt + ferr_cnt + ovr_cnt;
    @(negedge clk);
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (12 * BIT_CLK) @(negedge clk);
    check_int("glitch_no_pulse", done_cnt + ferr_cnt + ovr_cnt - s0, 0);
    check_bit("glitch_empty", empty, 1'b1);
  endtask

  task automatic test_break();
    int d0 = done_cnt;
    int f0 = ferr_cnt;
    @(negedge clk);
    rx = 1'b0;
    repeat (30 * BIT_CLK) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
    check_int("break_ferr_once", ferr_cnt - f0, 1);
    check_int("break_no_done", done_cnt - d0, 0);
    check_bit("break_empty", empty, 1'b1);
    send_good(8'hC3);
    pop_check("break_recover_pop");
  endtask

  task automatic test_reset_mid_frame();
    int s0;
    send_good(8'h12);
    check_bit("rstmid_holding", empty, 1'b0);
    @(negedge clk);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    rx = 1'b0;
    repeat (BIT_CLK / 2) @(negedge clk);
    s0 = done_cnt + ferr_cnt + ovr_cnt;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    rst = 1'b1;
    exp_q.delete();
    model_cnt = 0;
    repeat (12 * BIT_CLK) @(negedge clk);
    check_bit("rstmid_empty", empty, 1'b1);
    check_int("rstmid_no_pulse", done_cnt + ferr_cnt + ovr_cnt - s0, 0);
    send_good(8'h7E);
    pop_check("rstmid_next_pop");
    check_bit("rstmid_empty_end", empty, 1'b1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_frame_err();
    test_glitch();
    test_break();
    test_reset_mid_frame();
    check_int("parity_err_none", perr_cnt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
